// File: rtl/chess_pkg.sv
// chess_pkg: shared definitions for the chess game core.
// Holds the piece and color encodings, the game FSM state type, the cursor
// reset position and the function that yields the starting position of any
// square. No ports; imported by the core and its debouncer.
package chess_pkg;

  localparam logic [2:0] PC_NONE   = 3'd0;
  localparam logic [2:0] PC_PAWN   = 3'd1;
  localparam logic [2:0] PC_KNIGHT = 3'd2;
  localparam logic [2:0] PC_BISHOP = 3'd3;
  localparam logic [2:0] PC_ROOK   = 3'd4;
  localparam logic [2:0] PC_QUEEN  = 3'd5;
  localparam logic [2:0] PC_KING   = 3'd6;

  localparam logic COLOR_WHITE = 1'b0;
  localparam logic COLOR_BLACK = 1'b1;

  localparam logic [3:0] SQ_EMPTY     = 4'h0;
  localparam logic [5:0] CURSOR_RESET = 6'd52;

  typedef enum logic [1:0] {
    ST_SELECT,
    ST_MOVE,
    ST_WRITE_DEST,
    ST_WRITE_SRC
  } game_state_t;

  // Starting code of a square; address = {row, col}, row 0 = black back rank.
  function automatic logic [3:0] initial_square(input logic [5:0] addr);
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] back;
    row = addr[5:3];
    col = addr[2:0];
    case (col)
      3'd0, 3'd7: back = PC_ROOK;
      3'd1, 3'd6: back = PC_KNIGHT;
      3'd2, 3'd5: back = PC_BISHOP;
      3'd3:       back = PC_QUEEN;
      default:    back = PC_KING;
    endcase
    case (row)
      3'd0:    initial_square = {COLOR_BLACK, back};
      3'd1:    initial_square = {COLOR_BLACK, PC_PAWN};
      3'd6:    initial_square = {COLOR_WHITE, PC_PAWN};
      3'd7:    initial_square = {COLOR_WHITE, back};
      default: initial_square = SQ_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/chess_game_core_debounce.sv
// input_debounce: turns one raw asynchronous push-button into a single-cycle
// press pulse.
// Ports:
//   full_clock  system clock
//   Reset       asynchronous, active-high
//   tick        shared sampling enable from the clock divider
//   btn         raw button level
//   pulse       one full_clock cycle wide, once per press
module input_debounce
  import chess_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 16
) (
  input  logic full_clock,
  input  logic Reset,
  input  logic tick,
  input  logic btn,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TICKS);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // The counter saturates at CNT_MAX, so the pulse fires only on the tick that
  // reaches it; a new press needs a tick with the input low to clear it.
  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      pulse   <= 1'b0;
      if (tick) begin
        if (!sync_p1) begin
          cnt <= '0;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_MAX - 1'b1) pulse <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/chess_game_core.sv
// chess_game_core: game core of the FPGA chess board.
// Divides the clock into a sampling tick, debounces the five buttons, runs the
// cursor/select/move FSM and owns the 64-square board store.
// Ports:
//   full_clock              system clock (100 MHz on the board)
//   Reset                   asynchronous, active-high
//   BtnL/R/U/D/C            raw push-buttons
//   board_flat[255:0]       square a at [4a+3:4a], code {color, piece}
//   cursor_addr[5:0]        {row, col} of the cursor
//   selected_piece_addr     square of the selected piece
//   hilite_selected_square  selection active
//   turn                    side to move, 0 = white, 1 = black
//   MemOE/MemWR/RamCS/FlashCS/QuadSpiFlashCS  tied high, memories disabled
module chess_game_core
  import chess_pkg::*;
#(
  parameter int TICK_DIV_BITS  = 12,
  parameter int DEBOUNCE_TICKS = 16
) (
  input  logic         full_clock,
  input  logic         Reset,
  input  logic         BtnL,
  input  logic         BtnR,
  input  logic         BtnU,
  input  logic         BtnD,
  input  logic         BtnC,
  output logic [255:0] board_flat,
  output logic [5:0]   cursor_addr,
  output logic [5:0]   selected_piece_addr,
  output logic         hilite_selected_square,
  output logic         turn,
  output logic         MemOE,
  output logic         MemWR,
  output logic         RamCS,
  output logic         FlashCS,
  output logic         QuadSpiFlashCS
);

  assign MemOE          = 1'b1;
  assign MemWR          = 1'b1;
  assign RamCS          = 1'b1;
  assign FlashCS        = 1'b1;
  assign QuadSpiFlashCS = 1'b1;

  logic [TICK_DIV_BITS-1:0] div_clk;
  logic                     tick;

  // tick is high for the one cycle in which div_clk has just wrapped to 0.
  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      div_clk <= '0;
      tick    <= 1'b0;
    end else begin
      div_clk <= div_clk + 1'b1;
      tick    <= (div_clk == '1);
    end
  end

  logic pulse_l, pulse_r, pulse_u, pulse_d, pulse_c;

  input_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_l (
    .full_clock(full_clock), .Reset(Reset), .tick(tick), .btn(BtnL), .pulse(pulse_l));
  input_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_r (
    .full_clock(full_clock), .Reset(Reset), .tick(tick), .btn(BtnR), .pulse(pulse_r));
  input_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_u (
    .full_clock(full_clock), .Reset(Reset), .tick(tick), .btn(BtnU), .pulse(pulse_u));
  input_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_d (
    .full_clock(full_clock), .Reset(Reset), .tick(tick), .btn(BtnD), .pulse(pulse_d));
  input_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_c (
    .full_clock(full_clock), .Reset(Reset), .tick(tick), .btn(BtnC), .pulse(pulse_c));

  game_state_t state;
  logic [3:0]  board [64];
  logic [5:0]  dest_addr;
  logic [3:0]  cursor_sq;
  logic [3:0]  sel_sq;
  logic [2:0]  cur_row;
  logic [2:0]  cur_col;
  logic        own_piece;

  assign cursor_sq = board[cursor_addr];
  assign sel_sq    = board[selected_piece_addr];
  assign cur_row   = cursor_addr[5:3];
  assign cur_col   = cursor_addr[2:0];
  assign own_piece = (cursor_sq[2:0] != PC_NONE) && (cursor_sq[3] == turn);

  always_comb begin
    board_flat = '0;
    for (int i = 0; i < 64; i++) board_flat[4*i +: 4] = board[i];
  end

  // Single write port: WRITE_DEST copies the piece, WRITE_SRC clears the
  // origin, so a move always takes two cycles after the confirming press.
  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      state                  <= ST_SELECT;
      cursor_addr            <= CURSOR_RESET;
      selected_piece_addr    <= '0;
      hilite_selected_square <= 1'b0;
      turn                   <= COLOR_WHITE;
      dest_addr              <= '0;
      for (int i = 0; i < 64; i++) board[i] <= initial_square(6'(i));
    end else begin
      case (state)
        ST_SELECT, ST_MOVE: begin
          // Priority C > U > D > L > R; lower-priority pulses in the same
          // cycle are dropped.
          if (pulse_c) begin
            if (state == ST_SELECT) begin
              if (own_piece) begin
                selected_piece_addr    <= cursor_addr;
                hilite_selected_square <= 1'b1;
                state                  <= ST_MOVE;
              end
            end else if (cursor_addr == selected_piece_addr) begin
              hilite_selected_square <= 1'b0;
              state                  <= ST_SELECT;
            end else if (own_piece) begin
              selected_piece_addr <= cursor_addr;
            end else begin
              dest_addr <= cursor_addr;
              state     <= ST_WRITE_DEST;
            end
          end else if (pulse_u) begin
            if (cur_row != 3'd0) cursor_addr <= {cur_row - 3'd1, cur_col};
          end else if (pulse_d) begin
            if (cur_row != 3'd7) cursor_addr <= {cur_row + 3'd1, cur_col};
          end else if (pulse_l) begin
            if (cur_col != 3'd0) cursor_addr <= {cur_row, cur_col - 3'd1};
          end else if (pulse_r) begin
            if (cur_col != 3'd7) cursor_addr <= {cur_row, cur_col + 3'd1};
          end
        end
        ST_WRITE_DEST: begin
          board[dest_addr] <= sel_sq;
          state            <= ST_WRITE_SRC;
        end
        ST_WRITE_SRC: begin
          board[selected_piece_addr] <= SQ_EMPTY;
          hilite_selected_square     <= 1'b0;
          turn                       <= ~turn;
          state                      <= ST_SELECT;
        end
        default: state <= ST_SELECT;
      endcase
    end
  end

endmodule

// File: tb/tb_chess_game_core.sv
// Self-checking bench for chess_game_core with TICK_DIV_BITS=2, DEBOUNCE_TICKS=3.
// A small game model predicts the outputs of each button press; predictions
// are queued when the press is driven and compared once the press settles.
module tb_chess_game_core;
  import chess_pkg::*;

  localparam int B_L = 0, B_R = 1, B_U = 2, B_D = 3, B_C = 4;

  logic         full_clock = 1'b0;
  logic         Reset = 1'b1;
  logic         BtnL = 1'b0, BtnR = 1'b0, BtnU = 1'b0, BtnD = 1'b0, BtnC = 1'b0;
  logic [255:0] board_flat;
  logic [5:0]   cursor_addr;
  logic [5:0]   selected_piece_addr;
  logic         hilite_selected_square;
  logic         turn;
  logic         MemOE, MemWR, RamCS, FlashCS, QuadSpiFlashCS;

  chess_game_core #(.TICK_DIV_BITS(2), .DEBOUNCE_TICKS(3)) dut (
    .full_clock(full_clock), .Reset(Reset),
    .BtnL(BtnL), .BtnR(BtnR), .BtnU(BtnU), .BtnD(BtnD), .BtnC(BtnC),
    .board_flat(board_flat), .cursor_addr(cursor_addr),
    .selected_piece_addr(selected_piece_addr),
    .hilite_selected_square(hilite_selected_square), .turn(turn),
    .MemOE(MemOE), .MemWR(MemWR), .RamCS(RamCS), .FlashCS(FlashCS),
    .QuadSpiFlashCS(QuadSpiFlashCS));

  always #5 full_clock = ~full_clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state
  logic [3:0] m_board [64];
  logic [5:0] m_cur, m_sel;
  logic       m_hi, m_turn;

  typedef struct {
    string        tag;
    logic [5:0]   cur;
    logic [5:0]   sel;
    logic         hi;
    logic         trn;
    logic [255:0] flat;
  } snap_t;
  snap_t sb[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    logic [3:0] blk [8];
    logic [3:0] wht [8];
    blk = '{4'hC, 4'hA, 4'hB, 4'hD, 4'hE, 4'hB, 4'hA, 4'hC};
    wht = '{4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h3, 4'h2, 4'h4};
    for (int i = 0; i < 64; i++) m_board[i] = 4'h0;
    for (int c = 0; c < 8; c++) begin
      m_board[c]      = blk[c];
      m_board[8 + c]  = 4'h9;
      m_board[48 + c] = 4'h1;
      m_board[56 + c] = wht[c];
    end
    m_cur = 6'd52; m_sel = 6'd0; m_hi = 1'b0; m_turn = 1'b0;
  endfunction

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < 64; i++) f[4*i +: 4] = m_board[i];
    return f;
  endfunction

  function automatic void model_press(input int b);
    logic [3:0] pc;
    logic       own;
    pc  = m_board[m_cur];
    own = (pc[2:0] != 3'd0) && (pc[3] == m_turn);
    case (b)
      B_U: if (m_cur >= 6'd8)      m_cur = m_cur - 6'd8;
      B_D: if (m_cur < 6'd56)      m_cur = m_cur + 6'd8;
      B_L: if (m_cur[2:0] != 3'd0) m_cur = m_cur - 6'd1;
      B_R: if (m_cur[2:0] != 3'd7) m_cur = m_cur + 6'd1;
      default: begin
        if (!m_hi) begin
          if (own) begin m_sel = m_cur; m_hi = 1'b1; end
        end else if (m_cur == m_sel) begin
          m_hi = 1'b0;
        end else if (own) begin
          m_sel = m_cur;
        end else begin
          m_board[m_cur] = m_board[m_sel];
          m_board[m_sel] = 4'h0;
          m_hi   = 1'b0;
          m_turn = ~m_turn;
        end
      end
    endcase
  endfunction

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_L: BtnL = v;
      B_R: BtnR = v;
      B_U: BtnU = v;
      B_D: BtnD = v;
      default: BtnC = v;
    endcase
  endtask

  task automatic check_all(input snap_t s);
    chk({s.tag, "_cursor"}, 256'(cursor_addr), 256'(s.cur));
    chk({s.tag, "_sel"},    256'(selected_piece_addr), 256'(s.sel));
    chk({s.tag, "_hilite"}, 256'(hilite_selected_square), 256'(s.hi));
    chk({s.tag, "_turn"},   256'(turn), 256'(s.trn));
    chk({s.tag, "_board"},  board_flat, s.flat);
  endtask

  // Press, hold 20 clocks (well past 3 ticks after sync), release long enough
  // for a low tick to clear the debounce counter, then compare.
  task automatic press(input int b, input string tag);
    snap_t s;
    @(negedge full_clock);
    set_btn(b, 1'b1);
    model_press(b);
    s.tag = tag; s.cur = m_cur; s.sel = m_sel; s.hi = m_hi; s.trn = m_turn;
    s.flat = model_flat();
    sb.push_back(s);
    repeat (20) @(negedge full_clock);
    set_btn(b, 1'b0);
    repeat (12) @(negedge full_clock);
    check_all(sb.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    snap_t s;
    bit    found;
    model_reset();
    repeat (3) @(negedge full_clock);
    Reset = 1'b0;
    repeat (2) @(negedge full_clock);

    s.tag = "reset"; s.cur = m_cur; s.sel = m_sel; s.hi = m_hi; s.trn = m_turn;
    s.flat = model_flat();
    check_all(s);
    chk("mem_strobes", 256'({MemOE, MemWR, RamCS, FlashCS, QuadSpiFlashCS}), 256'(5'h1F));
    chk("reset_cursor52", 256'(cursor_addr), 256'(52));

    // Held button: one pulse only
    press(B_U, "hold_u");
    chk("hold_u_cursor44", 256'(cursor_addr), 256'(44));

    // Bouncing input: toggles every tick period, never counts to 3
    for (int i = 0; i < 10; i++) begin
      @(negedge full_clock); BtnU = 1'b1;
      repeat (3) @(negedge full_clock);
      @(negedge full_clock); BtnU = 1'b0;
      repeat (3) @(negedge full_clock);
    end
    repeat (12) @(negedge full_clock);
    chk("bounce_cursor", 256'(cursor_addr), 256'(44));

    // Wrong colour select is ignored
    for (int i = 0; i < 4; i++) press(B_U, "up_to_12");
    press(B_C, "c_black_12");
    chk("c_black_hilite0", 256'(hilite_selected_square), 256'(0));

    // Select, reselect, then move a white pawn 52 -> 36
    for (int i = 0; i < 5; i++) press(B_D, "down_to_52");
    press(B_C, "sel_52");
    press(B_R, "right_53");
    press(B_C, "resel_53");
    chk("resel_sel53", 256'(selected_piece_addr), 256'(53));
    press(B_L, "left_52");
    press(B_C, "resel_52");
    press(B_U, "up_44");
    press(B_U, "up_36");
    press(B_C, "move_36");
    chk("move_sq36", 256'(board_flat[36*4 +: 4]), 256'(4'h1));
    chk("move_sq52", 256'(board_flat[52*4 +: 4]), 256'(4'h0));
    chk("move_turn1", 256'(turn), 256'(1));

    // Edge saturation at 0 and 63
    for (int i = 0; i < 4; i++) press(B_U, "to_row0");
    for (int i = 0; i < 4; i++) press(B_L, "to_col0");
    press(B_U, "sat_u0");
    press(B_L, "sat_l0");
    chk("sat_cursor0", 256'(cursor_addr), 256'(0));
    for (int i = 0; i < 7; i++) press(B_D, "to_row7");
    for (int i = 0; i < 7; i++) press(B_R, "to_col7");
    press(B_D, "sat_d63");
    press(B_R, "sat_r63");
    chk("sat_cursor63", 256'(cursor_addr), 256'(63));

    // Black selects rook at 7 and targets empty 23; reset lands in WRITE_DEST
    for (int i = 0; i < 7; i++) press(B_U, "up_to_7");
    press(B_C, "sel_7");
    press(B_D, "down_15");
    press(B_D, "down_23");
    found = 1'b0;
    @(negedge full_clock);
    BtnC = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge full_clock);
      if (dut.state == ST_WRITE_DEST) found = 1'b1;
    end
    chk("reached_write_dest", 256'(found), 256'(1));
    Reset = 1'b1;
    #1;
    model_reset();
    chk("midreset_board_async", board_flat, model_flat());
    repeat (2) @(negedge full_clock);
    BtnC = 1'b0;
    repeat (2) @(negedge full_clock);
    Reset = 1'b0;
    repeat (12) @(negedge full_clock);
    s.tag = "midreset"; s.cur = m_cur; s.sel = m_sel; s.hi = m_hi; s.trn = m_turn;
    s.flat = model_flat();
    check_all(s);
    chk("midreset_state", 256'(dut.state), 256'(ST_SELECT));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
